// File: rtl/sprite_line_engine.sv
// Scanline sprite engine: descriptor and bitmap registers on the SoC bus, a
// per-hblank evaluator that selects and fetches up to MAX_PER_LINE sprites
// for the next line, and a one-cycle-latency pixel compositor.
module sprite_line_engine #(
    parameter int NUM_SPRITES  = 8,
    parameter int MAX_PER_LINE = 4,
    parameter int SPRITE_W     = 16,
    parameter int SPRITE_H     = 16,
    parameter int NUM_IMAGES   = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_sel,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic [9:0]  xpos,
    input  logic        video_active,
    output logic        pix_opaque,
    output logic [2:0]  pix_rgb
);

    localparam int IW  = $clog2(NUM_IMAGES);
    localparam int RW  = $clog2(SPRITE_H);
    localparam int XW  = $clog2(SPRITE_W);
    localparam int AW  = IW + RW;
    localparam int SIW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CW  = $clog2(MAX_PER_LINE + 1);

    localparam logic [9:0]    H10    = 10'(SPRITE_H);
    localparam logic [9:0]    W10    = 10'(SPRITE_W);
    localparam logic [CW-1:0] MAXC   = CW'(MAX_PER_LINE);
    localparam logic [SIW-1:0] LASTS = SIW'(NUM_SPRITES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, COMMIT} state_t;

    // Register file and flags
    logic [31:0] desc [NUM_SPRITES];
    logic        overflow, collision, late, busy;

    // Bus decode
    logic        bus_acc, bus_wr, reg_space, bm_we;
    logic [5:0]  word_idx;
    logic [31:0] rd_word;
    logic [2:0]  stat_clr;
    logic [AW-1:0] bm_waddr;

    // Bitmap RAM (write port: bus, read port: fetch)
    logic [SPRITE_W-1:0] bitmap [NUM_IMAGES*SPRITE_H];
    logic [AW-1:0]       bm_raddr;
    logic [SPRITE_W-1:0] bm_q;

    // Evaluator control
    state_t         state;
    logic [9:0]     ly;
    logic [SIW-1:0] scan_idx;
    logic [CW-1:0]  sh_cnt, act_cnt, fetch_idx;
    logic [31:0]    cur;
    logic [9:0]     dy;
    logic           hit, scan_store, scan_over;

    // Shadow (being built) and active (displayed) slots
    logic [9:0]          sh_x    [MAX_PER_LINE];
    logic [2:0]          sh_rgb  [MAX_PER_LINE];
    logic [RW-1:0]       sh_row  [MAX_PER_LINE];
    logic [IW-1:0]       sh_img  [MAX_PER_LINE];
    logic [SPRITE_W-1:0] sh_bits [MAX_PER_LINE];
    logic [9:0]          act_x    [MAX_PER_LINE];
    logic [2:0]          act_rgb  [MAX_PER_LINE];
    logic [SPRITE_W-1:0] act_bits [MAX_PER_LINE];

    // Compositor combinational stage
    logic       win_opaque_p0, multi_p0, slot_on;
    logic [2:0] win_rgb_p0;
    logic [9:0] dx;

    logic unused_bits;
    assign unused_bits = ^{iomem_addr[31:16], iomem_addr[14:8], iomem_addr[1:0],
                           cur[30:29], cur[25:20]};

    // Decode the bus request and form the readback word
    always_comb begin
        bus_acc   = iomem_valid && iomem_sel && !iomem_ready;
        bus_wr    = bus_acc && (iomem_wstrb != 4'b0000);
        reg_space = !iomem_addr[15];
        word_idx  = iomem_addr[7:2];
        bm_we     = bus_wr && iomem_addr[15];
        bm_waddr  = iomem_addr[2 +: AW];
        busy      = (state != IDLE);
        stat_clr  = 3'b000;
        if (bus_wr && reg_space && word_idx == 6'd63 && iomem_wstrb[0])
            stat_clr = iomem_wdata[3:1];
        rd_word = '0;
        if (reg_space) begin
            if (word_idx == 6'd63)
                rd_word = {28'b0, late, collision, overflow, busy};
            for (int i = 0; i < NUM_SPRITES; i++)
                if (word_idx == i[5:0]) rd_word = desc[i];
        end
    end

    // One-cycle acknowledge with registered read data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= bus_acc;
            iomem_rdata <= (bus_acc && !bus_wr) ? rd_word : '0;
        end
    end

    // Byte-strobed descriptor writes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_SPRITES; i++) desc[i] <= '0;
        end else if (bus_wr && reg_space) begin
            for (int i = 0; i < NUM_SPRITES; i++)
                if (word_idx == i[5:0])
                    for (int b = 0; b < 4; b++)
                        if (iomem_wstrb[b]) desc[i][8*b +: 8] <= iomem_wdata[8*b +: 8];
        end
    end

    // Bitmap RAM: bus writes whole words, fetch reads with one cycle latency
    always_ff @(posedge clk) begin
        if (bm_we) bitmap[bm_waddr] <= iomem_wdata[SPRITE_W-1:0];
        bm_q <= bitmap[bm_raddr];
    end

    // Current scan descriptor, vertical hit test and fetch address
    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_SPRITES; i++)
            if (scan_idx == SIW'(i)) cur = desc[i];
        dy         = ly - cur[19:10];
        hit        = (state == SCAN) && !line_start && cur[31] && (dy < H10);
        scan_store = hit && (sh_cnt < MAXC);
        scan_over  = hit && !(sh_cnt < MAXC);
        bm_raddr   = '0;
        for (int s = 0; s < MAX_PER_LINE; s++)
            if (fetch_idx == CW'(s)) bm_raddr = {sh_img[s], sh_row[s]};
    end

    // Line evaluator: IDLE -> SCAN -> FETCH -> COMMIT, restarted by any line_start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            scan_idx  <= '0;
            sh_cnt    <= '0;
            act_cnt   <= '0;
            fetch_idx <= '0;
        end else if (line_start) begin
            state    <= SCAN;
            scan_idx <= '0;
            sh_cnt   <= '0;
            act_cnt  <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (scan_store) sh_cnt <= sh_cnt + 1'b1;
                    if (scan_idx == LASTS) begin
                        state     <= FETCH;
                        fetch_idx <= '0;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                FETCH: begin
                    if (fetch_idx == sh_cnt) state <= COMMIT;
                    else fetch_idx <= fetch_idx + 1'b1;
                end
                COMMIT: begin
                    act_cnt <= sh_cnt;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slot contents: latch line, fill shadow slots, capture fetched rows, publish on commit
    always_ff @(posedge clk) begin
        if (line_start) ly <= line_y;
        for (int s = 0; s < MAX_PER_LINE; s++) begin
            if (scan_store && sh_cnt == CW'(s)) begin
                sh_x[s]   <= cur[9:0];
                sh_rgb[s] <= cur[28:26];
                sh_row[s] <= dy[RW-1:0];
                sh_img[s] <= cur[20 +: IW];
            end
            if (state == FETCH && fetch_idx == CW'(s + 1))
                sh_bits[s] <= bm_q;
            if (state == COMMIT) begin
                act_x[s]    <= sh_x[s];
                act_rgb[s]  <= sh_rgb[s];
                act_bits[s] <= sh_bits[s];
            end
        end
    end

    // Priority composite: first opaque slot wins, a second opaque slot flags collision
    always_comb begin
        win_opaque_p0 = 1'b0;
        win_rgb_p0    = 3'b000;
        multi_p0      = 1'b0;
        dx            = '0;
        slot_on       = 1'b0;
        for (int s = 0; s < MAX_PER_LINE; s++) begin
            dx      = xpos - act_x[s];
            slot_on = (CW'(s) < act_cnt) && (dx < W10) && act_bits[s][~dx[XW-1:0]];
            if (slot_on) begin
                if (win_opaque_p0) begin
                    multi_p0 = 1'b1;
                end else begin
                    win_opaque_p0 = 1'b1;
                    win_rgb_p0    = act_rgb[s];
                end
            end
        end
    end

    // Registered pixel output, blanked outside active video
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_opaque <= 1'b0;
            pix_rgb    <= 3'b000;
        end else begin
            pix_opaque <= video_active && win_opaque_p0;
            pix_rgb    <= (video_active && win_opaque_p0) ? win_rgb_p0 : 3'b000;
        end
    end

    // Sticky status flags; a hardware set in the same cycle beats a bus clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            collision <= 1'b0;
            late      <= 1'b0;
        end else begin
            overflow  <= (overflow  && !stat_clr[0]) || scan_over;
            collision <= (collision && !stat_clr[1]) || (video_active && multi_p0);
            late      <= (late      && !stat_clr[2]) || (line_start && state != IDLE);
        end
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine: bus access, line evaluation,
// compositing priority, wrap, status flags, late restart and reset.
module tb_sprite_line_engine;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iomem_sel, iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
    logic        iomem_ready;
    logic        line_start;
    logic [9:0]  line_y, xpos;
    logic        video_active;
    logic        pix_opaque;
    logic [2:0]  pix_rgb;

    int checks = 0;
    int passes = 0;
    logic [31:0] r;

    sprite_line_engine dut (
        .clk(clk), .resetn(resetn),
        .iomem_sel(iomem_sel), .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .iomem_ready(iomem_ready),
        .line_start(line_start), .line_y(line_y), .xpos(xpos),
        .video_active(video_active), .pix_opaque(pix_opaque), .pix_rgb(pix_rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mkdesc(input logic en, input int x, input int y,
                                          input int img, input int rgb);
        logic [9:0] xv, yv;
        logic [5:0] iv;
        logic [2:0] cv;
        xv = 10'(x); yv = 10'(y); iv = 6'(img); cv = 3'(rgb);
        return {en, 2'b00, cv, iv, yv, xv};
    endfunction

    function automatic logic [31:0] bmaddr(input int img, input int row);
        return 32'h8000 | 32'((img * 16 + row) * 4);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rv);
        int n;
        iomem_valid = 1'b1; iomem_sel = 1'b1;
        iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!iomem_ready && n < 8);
        if (!iomem_ready) check("bus_ready_timeout", 32'(iomem_ready), 32'd1);
        rv = iomem_rdata;
        iomem_valid = 1'b0; iomem_sel = 1'b0; iomem_wstrb = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(a, d, 4'hf, dummy);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] rv);
        bus_xfer(a, 32'h0, 4'h0, rv);
    endtask

    task automatic pulse_line(input int y);
        line_start = 1'b1; line_y = 10'(y);
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic show(input string tag, input int x, input int opq, input int rgb);
        xpos = 10'(x);
        @(posedge clk); #1;
        check({tag, "_opaque"}, 32'(pix_opaque), 32'(opq));
        check({tag, "_rgb"}, 32'(pix_rgb), 32'(rgb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; iomem_sel = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        iomem_addr = '0; iomem_wdata = '0; line_start = 1'b0; line_y = '0;
        xpos = '0; video_active = 1'b0;
        cyc(3);
        check("rst_pix_opaque", 32'(pix_opaque), 32'd0);
        check("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        resetn = 1'b1;
        cyc(1);

        // 1: single sprite, edge pixels of one row
        rd(32'hFC, r); check("t1_status_rst", r, 32'd0);
        rd(32'h00, r); check("t1_desc0_rst", r, 32'd0);
        wr(32'h00, mkdesc(1, 100, 50, 1, 1));
        rd(32'h00, r); check("t1_desc0_rb", r, 32'h8410C864);
        bus_xfer(32'h04, 32'hFFFFFFFF, 4'b0001, r);
        rd(32'h04, r); check("t1_desc1_bytestrobe", r, 32'h000000FF);
        wr(32'h04, 32'h0);
        wr(bmaddr(1, 2), 32'h8001);
        rd(bmaddr(1, 2), r); check("t1_bitmap_read_zero", r, 32'd0);
        pulse_line(52);
        cyc(20);
        video_active = 1'b1;
        for (int x = 98; x <= 117; x++) begin
            xpos = 10'(x);
            @(posedge clk); #1;
            check("t1_sweep_opaque", 32'(pix_opaque), 32'((x == 100) || (x == 115)));
            check("t1_sweep_rgb", 32'(pix_rgb), ((x == 100) || (x == 115)) ? 32'd1 : 32'd0);
        end
        video_active = 1'b0;
        cyc(1);

        // 2: six sprites on one line, only four slots
        wr(bmaddr(2, 0), 32'hFFFF);
        for (int i = 0; i < 6; i++) wr(32'(i * 4), mkdesc(1, 200 + 20 * i, 10, 2, i + 1));
        pulse_line(10);
        cyc(13);
        rd(32'hFC, r); check("t2_status_busy_ovf", r, 32'd3);
        rd(32'hFC, r); check("t2_status_idle_ovf", r, 32'd2);
        video_active = 1'b1;
        show("t2_spr0", 200, 1, 1);
        show("t2_spr3", 265, 1, 4);
        show("t2_gap", 219, 0, 0);
        show("t2_spr4_dropped", 285, 0, 0);
        show("t2_spr5_dropped", 305, 0, 0);
        video_active = 1'b0;
        wr(32'hFC, 32'hE);
        rd(32'hFC, r); check("t2_status_cleared", r, 32'd0);

        // 3: overlapping sprites, priority and collision
        wr(32'h00, 32'h0); wr(32'h04, 32'h0); wr(32'h0C, 32'h0); wr(32'h10, 32'h0);
        wr(32'h08, mkdesc(1, 400, 10, 2, 2));
        wr(32'h14, mkdesc(1, 400, 10, 2, 4));
        pulse_line(10);
        cyc(20);
        video_active = 1'b1;
        show("t3_overlap", 405, 1, 2);
        video_active = 1'b0;
        show("t3_blank", 405, 0, 0);
        rd(32'hFC, r); check("t3_collision_set", r, 32'd4);
        wr(32'hFC, 32'h4);
        rd(32'hFC, r); check("t3_collision_clr", r, 32'd0);

        // 4: vertical and horizontal wrap
        wr(32'h08, 32'h0); wr(32'h14, 32'h0);
        wr(bmaddr(3, 7), 32'h0200);
        wr(bmaddr(3, 6), 32'hFFFF);
        wr(bmaddr(3, 0), 32'hFFFF);
        wr(32'h00, mkdesc(1, 1020, 1020, 3, 5));
        pulse_line(3);
        cyc(20);
        video_active = 1'b1;
        show("t4_col6", 2, 1, 5);
        show("t4_col5", 1, 0, 0);
        show("t4_col7", 3, 0, 0);
        show("t4_col0", 1020, 0, 0);
        show("t4_again", 2, 1, 5);

        // 5: second line_start while busy
        pulse_line(3);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check("t5_blank_first", 32'(pix_opaque), 32'd0);
        end
        pulse_line(1020);
        check("t5_blank_restart", 32'(pix_opaque), 32'd0);
        for (int k = 6; k <= 16; k++) begin
            @(posedge clk); #1;
            check("t5_blank_second", 32'(pix_opaque), 32'd0);
        end
        @(posedge clk); #1;
        check("t5_after_commit_opaque", 32'(pix_opaque), 32'd1);
        check("t5_after_commit_rgb", 32'(pix_rgb), 32'd5);
        show("t5_row0", 1, 1, 5);
        rd(32'hFC, r); check("t5_late", r, 32'd8);

        // 6: asynchronous reset during FETCH
        xpos = 10'd2;
        pulse_line(3);
        cyc(8);
        iomem_valid = 1'b1; iomem_sel = 1'b1; iomem_addr = 32'h0; iomem_wstrb = 4'h0;
        cyc(1);
        check("t6_pre_ready", 32'(iomem_ready), 32'd1);
        check("t6_pre_rdata", iomem_rdata, mkdesc(1, 1020, 1020, 3, 5));
        iomem_valid = 1'b0; iomem_sel = 1'b0;
        resetn = 1'b0;
        #2;
        check("t6_ready", 32'(iomem_ready), 32'd0);
        check("t6_rdata", iomem_rdata, 32'd0);
        check("t6_pix_opaque", 32'(pix_opaque), 32'd0);
        check("t6_pix_rgb", 32'(pix_rgb), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        cyc(1);
        rd(32'hFC, r); check("t6_status", r, 32'd0);
        rd(32'h00, r); check("t6_desc0", r, 32'd0);
        pulse_line(3);
        cyc(20);
        show("t6_no_sprite", 2, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
